muldiv_sequencer: RTL and testbench

//  Iterative multiply/divide engine with its own sequencing FSM and start/busy/done handshake.
//  The control unit stalls the PC on busy instead of running its own 32-cycle counter.
//  It replaces the mul32 + counter arrangement and implements the missing DIV/REM.

---
 rtl/muldiv_sequencer.sv | 136 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative signed/unsigned multiply and divide engine with start/busy/done handshake.
// One shift-add or restoring-divide step per cycle, then a sign-fix cycle.
module muldiv_sequencer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             div_by_zero
);

   localparam logic [1:0] OP_MUL  = 2'd0;
   localparam logic [1:0] OP_DIV  = 2'd1;
   localparam logic [1:0] OP_REM  = 2'd2;
   localparam logic [1:0] OP_DIVU = 2'd3;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t           state;
   logic [1:0]       op_q;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] acc;     // MUL accumulator / DIV partial remainder
   logic [WIDTH-1:0] ra;      // MUL shifted multiplicand / DIV dividend-then-quotient
   logic [WIDTH-1:0] rb;      // MUL shifted multiplier / DIV divisor magnitude
   logic             neg_res;
   logic             neg_rem;
   logic             bz;

   logic             signed_op;
   logic             sa;
   logic             sb;
   logic [WIDTH-1:0] mul_sum;
   logic [WIDTH:0]   sh_rem;
   logic [WIDTH:0]   trial;
   logic             borrow;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] fix_val;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
      return s ? WIDTH'(0) - x : x;
   endfunction

   // Operand sign decode for the accept edge
   always_comb begin
      signed_op = (op != OP_DIVU);
      sa        = signed_op & a[WIDTH-1];
      sb        = signed_op & b[WIDTH-1];
   end

   // One iteration of shift-add and of restoring division
   always_comb begin
      mul_sum  = acc + (rb[0] ? ra : WIDTH'(0));
      sh_rem   = {acc, ra[WIDTH-1]};
      trial    = sh_rem - {1'b0, rb};
      borrow   = trial[WIDTH];
      rem_next = borrow ? sh_rem[WIDTH-1:0] : trial[WIDTH-1:0];
   end

   // Sign correction; a zero divisor leaves rem=|a|, so REM naturally returns a
   always_comb begin
      fix_val = acc;
      case (op_q)
         OP_MUL:          fix_val = neg_res ? WIDTH'(0) - acc : acc;
         OP_DIV, OP_DIVU: fix_val = bz ? '1 : (neg_res ? WIDTH'(0) - ra : ra);
         OP_REM:          fix_val = neg_rem ? WIDTH'(0) - acc : acc;
         default:         fix_val = acc;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         result      <= '0;
         div_by_zero <= 1'b0;
         op_q        <= OP_MUL;
         cnt         <= '0;
         acc         <= '0;
         ra          <= '0;
         rb          <= '0;
         neg_res     <= 1'b0;
         neg_rem     <= 1'b0;
         bz          <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  state   <= RUN;
                  busy    <= 1'b1;
                  op_q    <= op;
                  cnt     <= '0;
                  acc     <= '0;
                  ra      <= mag(a, sa);
                  rb      <= mag(b, sb);
                  neg_res <= sa ^ sb;
                  neg_rem <= sa;
                  bz      <= (op != OP_MUL) && (b == '0);
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               if (op_q == OP_MUL) begin
                  acc <= mul_sum;
                  ra  <= ra << 1;
                  rb  <= rb >> 1;
               end else begin
                  acc <= rem_next;
                  ra  <= {ra[WIDTH-2:0], ~borrow};
               end
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST_CNT) state <= FIX;
            end
            FIX: begin
               result      <= fix_val;
               div_by_zero <= bz;
               busy        <= 1'b0;
               done        <= 1'b1;
               state       <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_sequencer;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned LAT   = WIDTH + 1;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             div_by_zero;

   int checks = 0;
   int errors = 0;

   muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   // Reference: returns {div_by_zero, result}
   function automatic logic [WIDTH:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy;
      logic [63:0] r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (o == 2'd0) begin
         r = 64'(sx * sy);
         return {1'b0, r[31:0]};
      end
      if (y == 32'd0) return {1'b1, (o == 2'd2) ? x : 32'hFFFF_FFFF};
      case (o)
         2'd1:    r = 64'(sx / sy);
         2'd2:    r = 64'(sx % sy);
         default: r = {32'd0, x / y};
      endcase
      return {1'b0, r[31:0]};
   endfunction

   // Launch one op; operands are scrambled right after the accept edge
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic z, output int lat, output int bcnt);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
      lat = 0; bcnt = 0;
      while (!done && lat < 100) begin
         if (busy) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
      r = result; z = div_by_zero;
   endtask

   task automatic check_op(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] r; logic z; int lat, bcnt; logic [WIDTH:0] exp;
      exp = model(o, x, y);
      run_op(o, x, y, r, z, lat, bcnt);
      checks++;
      if (r !== exp[31:0] || z !== exp[32]) begin
         errors++;
         $display("FAIL %s op=%0d a=%h b=%h: got result=%h dbz=%b, expected result=%h dbz=%b",
                  name, o, x, y, r, z, exp[31:0], exp[32]);
      end
      checks++;
      if (lat != LAT || bcnt != LAT || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s latency: got lat=%0d busy_cycles=%0d busy_at_done=%b, expected %0d/%0d/0",
                  name, lat, bcnt, busy, LAT, LAT);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b result=%h dbz=%b, expected all 0", busy, done, result, div_by_zero);
      end
      repeat (3) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
   endtask

   task automatic test_directed();
      check_op("mul_7_m3",    2'd0, 32'd7,          32'hFFFF_FFFD);
      check_op("mul_trunc",   2'd0, 32'h0001_0000,  32'h0001_0000);
      check_op("div_m7_2",    2'd1, 32'hFFFF_FFF9,  32'd2);
      check_op("rem_m7_2",    2'd2, 32'hFFFF_FFF9,  32'd2);
      check_op("divu_big",    2'd3, 32'hFFFF_FFFE,  32'd2);
      check_op("div_by_zero", 2'd1, 32'd5,          32'd0);
      check_op("rem_by_zero", 2'd2, 32'd5,          32'd0);
      check_op("divu_by_0",   2'd3, 32'h1234_5678,  32'd0);
      check_op("mul_after_z", 2'd0, 32'd3,          32'd4);
      check_op("div_min_m1",  2'd1, 32'h8000_0000,  32'hFFFF_FFFF);
      check_op("rem_min_m1",  2'd2, 32'h8000_0000,  32'hFFFF_FFFF);
      check_op("mul_min_m1",  2'd0, 32'h8000_0000,  32'hFFFF_FFFF);
      check_op("rem_7_m2",    2'd2, 32'd7,          32'hFFFF_FFFE);
   endtask

   task automatic test_random();
      logic [31:0] x, y;
      for (int i = 0; i < 40; i++) begin
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 5))
            0: y = 32'd0;
            1: y = 32'($urandom_range(1, 9));
            2: y = -32'($urandom_range(1, 9));
            3: x = 32'h8000_0000;
            default: ;
         endcase
         check_op("random", 2'($urandom_range(0, 3)), x, y);
      end
   endtask

   task automatic test_ignore_start();
      logic [31:0] prev; logic [WIDTH:0] exp; int lat;
      prev = result;
      exp = model(2'd1, 32'd1000, 32'd7);
      @(negedge clk);
      start = 1'b1; op = 2'd1; a = 32'd1000; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      repeat (9) begin @(posedge clk); #1; lat++; end
      @(negedge clk);
      start = 1'b1; op = 2'd0; a = 32'd9; b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      lat++;
      checks++;
      if (result !== prev || busy !== 1'b1) begin
         errors++;
         $display("FAIL ignore_mid_result: result=%h busy=%b, expected result=%h busy=1", result, busy, prev);
      end
      #1;
      while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat != LAT || result !== exp[31:0]) begin
         errors++;
         $display("FAIL ignore_start_done: lat=%0d result=%h, expected lat=%0d result=%h", lat, result, LAT, exp[31:0]);
      end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL ignore_no_queue: busy=%b done=%b, expected 0/0", busy, done);
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH:0] e1, e2; int lat;
      e1 = model(2'd0, 32'd123, 32'hFFFF_FF00);
      e2 = model(2'd2, 32'hFFFF_FC00, 32'd37);
      @(negedge clk);
      start = 1'b1; op = 2'd0; a = 32'd123; b = 32'hFFFF_FF00;
      @(posedge clk); #1;
      op = 2'd2; a = 32'hFFFF_FC00; b = 32'd37;
      lat = 0;
      while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat != LAT || result !== e1[31:0]) begin
         errors++;
         $display("FAIL b2b_first: lat=%0d result=%h, expected lat=%0d result=%h", lat, result, LAT, e1[31:0]);
      end
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_gap: busy=%b done=%b, expected busy=1 done=0", busy, done);
      end
      lat = 0;
      while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat != LAT || result !== e2[31:0] || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second: lat=%0d result=%h dbz=%b, expected lat=%0d result=%h dbz=0",
                  lat, result, div_by_zero, LAT, e2[31:0]);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      @(negedge clk);
      start = 1'b1; op = 2'd1; a = 32'd100; b = 32'd0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: busy=%b done=%b result=%h dbz=%b, expected all 0", busy, done, result, div_by_zero);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      seen = 0;
      repeat (45) begin
         @(posedge clk); #1;
         if (done || busy) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL reset_mid_no_done: %0d cycles with busy/done after release, expected 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
